// File: rtl/vscale_htif_pcr_host.sv
// Host-side initiator for the HTIF PCR (CSR) access channel.
// Accepts one read/write command at a time, issues a single htif_pcr_req,
// waits for the matching htif_pcr_resp and presents the result. A cycle
// counter aborts a transaction that stalls in REQ+WAIT too long.
`timescale 1ns/1ps
module vscale_htif_pcr_host #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  htif_pcr_req_valid,
  input  logic                  htif_pcr_req_ready,
  output logic                  htif_pcr_req_rw,
  output logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [DATA_WIDTH-1:0] htif_pcr_req_data,
  input  logic                  htif_pcr_resp_valid,
  output logic                  htif_pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0] htif_pcr_resp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // A zero timeout disables the abort; keep a 1-bit counter so widths stay legal.
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                state_r;
  logic                  rw_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  rsp_timeout_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  expire_s;

  // Expiry flag: this is the last permitted cycle in REQ+WAIT.
  always_comb begin
    expire_s = 1'b0;
    if (TO_EN) begin
      expire_s = (cnt_r == TO_LAST);
    end else begin
      expire_s = 1'b0;
    end
  end

  // Transaction FSM with command latches, result registers and timeout counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      rw_r          <= 1'b0;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      wdata_r       <= {DATA_WIDTH{1'b0}};
      rsp_data_r    <= {DATA_WIDTH{1'b0}};
      rsp_timeout_r <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            rw_r    <= cmd_rw;
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (TO_EN && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          // A handshake in the expiry cycle takes precedence over the abort.
          if (htif_pcr_req_ready) begin
            state_r <= ST_WAIT;
          end else if (expire_s) begin
            rsp_data_r    <= {DATA_WIDTH{1'b0}};
            rsp_timeout_r <= 1'b1;
            state_r       <= ST_RSP;
          end
        end
        ST_WAIT: begin
          if (TO_EN && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          if (htif_pcr_resp_valid) begin
            rsp_data_r    <= htif_pcr_resp_data;
            rsp_timeout_r <= 1'b0;
            state_r       <= ST_RSP;
          end else if (expire_s) begin
            rsp_data_r    <= {DATA_WIDTH{1'b0}};
            rsp_timeout_r <= 1'b1;
            state_r       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Every output is a decode of registered state or a registered value.
  assign cmd_ready           = (state_r == ST_IDLE);
  assign htif_pcr_req_valid  = (state_r == ST_REQ);
  assign htif_pcr_resp_ready = (state_r == ST_WAIT);
  assign rsp_valid           = (state_r == ST_RSP);
  assign busy                = (state_r != ST_IDLE);
  assign htif_pcr_req_rw     = rw_r;
  assign htif_pcr_req_addr   = addr_r;
  assign htif_pcr_req_data   = wdata_r;
  assign rsp_data            = rsp_data_r;
  assign rsp_timeout         = rsp_timeout_r;

endmodule

// File: tb/tb_vscale_htif_pcr_host.sv
// Directed bench for vscale_htif_pcr_host: reset, zero-wait read, write
// with request backpressure, timeout, expiry race, result backpressure and
// reset mid-transaction. The core side is driven by hand in each task.
`timescale 1ns/1ps
module tb_vscale_htif_pcr_host;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  vscale_htif_pcr_host #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_rw              (cmd_rw),
    .cmd_addr            (cmd_addr),
    .cmd_wdata           (cmd_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_timeout         (rsp_timeout),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    tick(); tick();
    reset = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if ({rsp_valid, req_valid, resp_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {rsp_valid, req_valid, resp_ready}); end
    n_checks++; if (rsp_data !== 64'h0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got data %h to %b want 0/0", rsp_data, rsp_timeout); end
    n_checks++; if (req_addr !== 12'h000 || req_data !== 64'h0 || req_rw !== 1'b0) begin n_fail++; $display("FAIL reset_latches: got %h %h %b want zeros", req_addr, req_data, req_rw); end
  endtask

  task automatic test_read_zero_wait();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h780; cmd_wdata = 64'h0;
    tick();                                   // accept edge N
    cmd_valid = 1'b0; req_ready = 1'b1;
    n_checks++; if (req_valid !== 1'b1 || req_addr !== 12'h780 || req_rw !== 1'b0) begin n_fail++; $display("FAIL read_req_n1: got v=%b a=%h rw=%b want 1/780/0", req_valid, req_addr, req_rw); end
    tick();                                   // req handshake edge N+1
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 64'h1;
    n_checks++; if (resp_ready !== 1'b1 || req_valid !== 1'b0) begin n_fail++; $display("FAIL read_wait_n2: got rr=%b rv=%b want 1/0", resp_ready, req_valid); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_early_rsp: got %b want 0", rsp_valid); end
    tick();                                   // cycle N+3
    resp_valid = 1'b0; rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h1 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL read_rsp_n3: got v=%b d=%h to=%b want 1/1/0", rsp_valid, rsp_data, rsp_timeout); end
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL read_back_idle: got rv=%b cr=%b want 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_write_backpressure();
    int hs = 0;
    int bad = 0;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h781; cmd_wdata = 64'hDEADBEEF;
    tick();
    cmd_valid = 1'b0; cmd_wdata = 64'h0; cmd_addr = 12'h000; req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (req_valid !== 1'b1 || req_rw !== 1'b1 || req_addr !== 12'h781 || req_data !== 64'hDEADBEEF) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL write_req_stable: got %0d unstable cycles want 0", bad); end
    req_ready = 1'b1;
    if (req_valid === 1'b1) hs++;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (req_valid === 1'b1) hs++;
      tick();
    end
    req_ready = 1'b0;
    n_checks++; if (hs != 1) begin n_fail++; $display("FAIL write_one_handshake: got %0d want 1", hs); end
    n_checks++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL write_in_wait: got %b want 1", resp_ready); end
    resp_valid = 1'b1; resp_data = 64'h0123456789ABCDEF;
    tick();
    resp_valid = 1'b0; resp_data = 64'h0; rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0123456789ABCDEF || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL write_rsp: got v=%b d=%h to=%b want 1/0123456789abcdef/0", rsp_valid, rsp_data, rsp_timeout); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int e = 0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h7C0;
    tick();                                   // REQ entered here
    cmd_valid = 1'b0; req_ready = 1'b1;
    while (rsp_valid !== 1'b1 && e < 40) begin
      tick();
      e++;
    end
    req_ready = 1'b0;
    n_checks++; if (e != 16) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want 16", e); end
    n_checks++; if (rsp_timeout !== 1'b1 || rsp_data !== 64'h0) begin n_fail++; $display("FAIL timeout_result: got to=%b d=%h want 1/0", rsp_timeout, rsp_data); end
    n_checks++; if (resp_ready !== 1'b0 || req_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_readies: got rr=%b rv=%b want 0/0", resp_ready, req_valid); end
    tick();
    rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got v=%b to=%b want 1/1", rsp_valid, rsp_timeout); end
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (resp_ready !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_after: got rr=%b cr=%b want 0/1", resp_ready, cmd_ready); end
  endtask

  task automatic test_race();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h7C1;
    tick();                                   // cycle N+1, counter 0
    cmd_valid = 1'b0; req_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();      // cycle N+16, counter at expiry
    req_ready = 1'b0;
    n_checks++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL race_still_wait: got %b want 1", resp_ready); end
    resp_valid = 1'b1; resp_data = 64'h55;
    tick();
    resp_valid = 1'b0; resp_data = 64'h0; rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_data !== 64'h55) begin n_fail++; $display("FAIL race_result: got v=%b to=%b d=%h want 1/0/55", rsp_valid, rsp_timeout, rsp_data); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h301;
    tick();
    req_ready = 1'b1;
    tick();
    resp_valid = 1'b1; resp_data = 64'hA5A5_5A5A_0F0F_F0F0;
    tick();
    resp_valid = 1'b0; resp_data = 64'h0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 64'hA5A5_5A5A_0F0F_F0F0 || cmd_ready !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rsp_bp_stable: got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rsp_bp_last: got rv=%b cr=%b want 1/0", rsp_valid, cmd_ready); end
    tick();                                   // RSP handshake edge
    rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rsp_bp_ready_after: got %b want 1", cmd_ready); end
    tick();                                   // held command accepted here
    cmd_valid = 1'b0;
    n_checks++; if (req_valid !== 1'b1 || req_addr !== 12'h301) begin n_fail++; $display("FAIL rsp_bp_next_accept: got v=%b a=%h want 1/301", req_valid, req_addr); end
    tick();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 64'h2;
    tick();
    resp_valid = 1'b0; resp_data = 64'h0; rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h2) begin n_fail++; $display("FAIL rsp_bp_second: got v=%b d=%h want 1/2", rsp_valid, rsp_data); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h782; cmd_wdata = 64'h99;
    tick();
    cmd_valid = 1'b0; req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    n_checks++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_wait: got %b want 1", resp_ready); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++; if ({busy, cmd_ready, rsp_valid, req_valid, resp_ready} !== 5'b01000) begin n_fail++; $display("FAIL rstmid_state: got %b want 01000", {busy, cmd_ready, rsp_valid, req_valid, resp_ready}); end
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h783;
    tick();
    cmd_valid = 1'b0; req_ready = 1'b1;
    n_checks++; if (req_valid !== 1'b1 || req_addr !== 12'h783 || req_rw !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got v=%b a=%h rw=%b want 1/783/0", req_valid, req_addr, req_rw); end
    tick();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 64'h77;
    tick();
    resp_valid = 1'b0; rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h77 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_read: got v=%b d=%h to=%b want 1/77/0", rsp_valid, rsp_data, rsp_timeout); end
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_backpressure();
    test_timeout();
    test_race();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
